apblink_req_arbiter: RTL

- Shares one APBLink master (APB slave port, 26-bit paddr, 32-bit data) between NREQ APB requesters, e.g. fabric user logic and a PCIe init/PERST sequencer.
- Round-robin arbitration with optional per-requester lock.
- Re-times each granted transfer into a clean SETUP/ACCESS sequence and returns pready/pslverr/prdata to the granted requester only.
- Sits directly upstream of the APBLink master, in the same pclk domain.

---
 rtl/apblink_arb_pkg.sv | 17 +
 rtl/apblink_rr_pick.sv | 28 ++
 rtl/apblink_req_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/apblink_arb_pkg.sv
// Shared types and widths for the APBLink requester arbiter.
package apblink_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam int TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/apblink_rr_pick.sv
// Round-robin picker: first set request bit searching upward from ptr+1, modulo NREQ.
module apblink_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  winner,
  output logic            valid
);

  logic [IDW-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest set bit is written last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apblink_req_arbiter.sv
// Round-robin arbiter sharing one APBLink master between NREQ APB requesters,
// with optional per-requester lock and a sticky ACCESS-phase timeout flag.
module apblink_req_arbiter
  import apblink_arb_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int IDW            = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   pclk,
  input  logic                   preset,
  input  logic [NREQ-1:0]        s_psel,
  input  logic [NREQ-1:0]        s_penable,
  input  logic [NREQ-1:0]        s_pwrite,
  input  logic [STRB_W*NREQ-1:0] s_pstrb,
  input  logic [ADDR_W*NREQ-1:0] s_paddr,
  input  logic [DATA_W*NREQ-1:0] s_pwdata,
  input  logic [NREQ-1:0]        s_lock,
  output logic [DATA_W-1:0]      s_prdata,
  output logic [NREQ-1:0]        s_pready,
  output logic [NREQ-1:0]        s_pslverr,
  output logic                   m_psel,
  output logic                   m_penable,
  output logic                   m_pwrite,
  output logic [STRB_W-1:0]      m_pstrb,
  output logic [ADDR_W-1:0]      m_paddr,
  output logic [DATA_W-1:0]      m_pwdata,
  input  logic [DATA_W-1:0]      m_prdata,
  input  logic                   m_pready,
  input  logic                   m_pslverr,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy,
  output logic                   to_flag,
  output logic [IDW-1:0]         to_id,
  input  logic                   to_clr,
  output state_t                 dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(TIMEOUT_CYCLES - 1);

  // Handshake: a requester holds s_psel and its fields until its one-cycle s_pready
  // pulse; the master side sees a plain SETUP/ACCESS pair completed by m_pready.

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic             lock_vld;
  logic [IDW-1:0]   lock_id;
  logic [CNT_W-1:0] to_cnt;
  logic [NREQ-1:0]  eligible;
  logic [IDW-1:0]   pick_id;
  logic             pick_vld;
  logic             unused_penable;

  // The block generates its own APB phases; requester penable carries no information.
  assign unused_penable = ^s_penable;

  assign eligible  = lock_vld ? (s_psel & (NREQ'(1) << lock_id)) : s_psel;
  assign busy      = (state == SETUP) || (state == ACCESS);
  assign dbg_state = state;

  apblink_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (eligible),
    .ptr    (rr_ptr),
    .winner (pick_id),
    .valid  (pick_vld)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      rr_ptr    <= IDW'(NREQ - 1);
      lock_vld  <= 1'b0;
      lock_id   <= '0;
      m_psel    <= 1'b0;
      m_penable <= 1'b0;
      m_pwrite  <= 1'b0;
      m_pstrb   <= '0;
      m_paddr   <= '0;
      m_pwdata  <= '0;
      s_pready  <= '0;
      s_pslverr <= '0;
      s_prdata  <= '0;
      grant_id  <= '0;
      to_flag   <= 1'b0;
      to_id     <= '0;
      to_cnt    <= '0;
    end else begin
      s_pready  <= '0;
      s_pslverr <= '0;
      if (to_clr) to_flag <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_vld) begin
            m_psel    <= 1'b1;
            m_penable <= 1'b0;
            m_pwrite  <= s_pwrite[pick_id];
            m_pstrb   <= s_pstrb[pick_id*STRB_W +: STRB_W];
            m_paddr   <= s_paddr[pick_id*ADDR_W +: ADDR_W];
            m_pwdata  <= s_pwdata[pick_id*DATA_W +: DATA_W];
            grant_id  <= pick_id;
            to_cnt    <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          m_penable <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (to_cnt != CNT_MAX) to_cnt <= to_cnt + 1'b1;
          // Set is placed after the clear above so a coincident set wins.
          if (to_cnt == CNT_HIT) begin
            to_flag <= 1'b1;
            to_id   <= grant_id;
          end
          if (m_pready) begin
            s_prdata            <= m_prdata;
            s_pready[grant_id]  <= 1'b1;
            s_pslverr[grant_id] <= m_pslverr;
            m_psel              <= 1'b0;
            m_penable           <= 1'b0;
            rr_ptr              <= grant_id;
            state               <= DONE;
          end
        end
        DONE: begin
          lock_vld <= s_lock[grant_id];
          lock_id  <= grant_id;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
